// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and helpers for the RV32I pipeline hazard
//                controller. It holds the forwarding-select encoding, the
//                sequencer states, the scoreboard entry layout and the
//                register-match helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // register file
        FWD_ME = 2'b01,   // ALU result held in EX/ME
        FWD_WB = 2'b10    // write-back data held in ME/WB
    } fwd_sel_e;

    // Hazard sequencer states
    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        RUN      = 2'b01,
        LU_STALL = 2'b10
    } hz_state_e;

    // One scoreboard slot, mirroring a pipeline register's destination info
    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } sb_entry_t;

    // ru_data_src encoding that marks a load in the decoder
    localparam logic [1:0] RU_SRC_LOAD = 2'b01;

    localparam sb_entry_t c_SB_BUBBLE = '{rd: 5'd0, wr: 1'b0, load: 1'b0};

    // A producer matches a consumer operand only if it really writes a
    // non-x0 register and the consumer actually reads that operand.
    function automatic logic sb_hit(
        input logic [4:0] rd,
        input logic       wr,
        input logic [4:0] rs,
        input logic       use_rs
    );
        return wr && (rd != 5'd0) && (rd == rs) && use_rs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Three-entry (EX/ME/WB) destination-register scoreboard that
//                shifts in lock-step with the pipeline registers, plus the
//                operand match logic that yields the next forwarding selects
//                and the load-use indication for the instruction in DE.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                i_shift            advance the scoreboard (pipeline not frozen)
//                i_bubble           insert a bubble instead of the DE entry
//                i_de_rd/wr/load    destination info of the DE instruction
//                i_rs1/2, i_use_rs1/2  DE source operands and their use flags
//                o_fwd_a/b          forwarding selects for DE operands
//                o_load_use         EX holds a load that DE depends on
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_shift,
    input  logic       i_bubble,
    input  logic [4:0] i_de_rd,
    input  logic       i_de_wr,
    input  logic       i_de_load,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_use_rs1,
    input  logic       i_use_rs2,
    output fwd_sel_e   o_fwd_a,
    output fwd_sel_e   o_fwd_b,
    output logic       o_load_use
);

    sb_entry_t r_ex;
    sb_entry_t r_me;
    sb_entry_t r_wb;

    logic w_ex_hit1;
    logic w_ex_hit2;
    logic w_me_hit1;
    logic w_me_hit2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= c_SB_BUBBLE;
            r_me <= c_SB_BUBBLE;
            r_wb <= c_SB_BUBBLE;
        end else if (i_shift) begin
            r_wb <= r_me;
            r_me <= r_ex;
            r_ex <= i_bubble ? c_SB_BUBBLE
                             : '{rd: i_de_rd, wr: i_de_wr, load: i_de_load};
        end
    end

    assign w_ex_hit1 = sb_hit(r_ex.rd, r_ex.wr, i_rs1, i_use_rs1);
    assign w_ex_hit2 = sb_hit(r_ex.rd, r_ex.wr, i_rs2, i_use_rs2);
    assign w_me_hit1 = sb_hit(r_me.rd, r_me.wr, i_rs1, i_use_rs1);
    assign w_me_hit2 = sb_hit(r_me.rd, r_me.wr, i_rs2, i_use_rs2);

    // A load in EX has no data to forward next cycle; that case becomes a
    // stall, so it falls through to the older ME entry here.
    function automatic fwd_sel_e pick_fwd(
        input logic ex_hit,
        input logic ex_load,
        input logic me_hit
    );
        if (ex_hit && !ex_load) begin
            return FWD_ME;
        end else if (me_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign o_fwd_a    = pick_fwd(w_ex_hit1, r_ex.load, w_me_hit1);
    assign o_fwd_b    = pick_fwd(w_ex_hit2, r_ex.load, w_me_hit2);
    assign o_load_use = r_ex.load && (w_ex_hit1 || w_ex_hit2);

    // The WB slot mirrors ME/WB for observability only: a WB producer
    // colliding with a DE read is resolved by register-file write-through.
    logic w_unused;
    assign w_unused = &{1'b0, r_me.load, r_wb};

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central hazard sequencer for the 5-stage RV32I pipeline.
//                Flushes the pipe for BOOT_CYCLES after reset, stalls one
//                cycle on load-use, flushes IF/DE and DE/EX on taken
//                branches, freezes everything on ext_stall, drives the EX
//                operand forwarding selects and counts stall/flush events.
//  Ports       : clk, reset             clock, synchronous active-high reset
//                de_*                   operand/destination info of DE instr
//                ex_branch_taken        taken branch/jump resolved in EX
//                ext_stall              external freeze request
//                pc_en, if_de_en        PC and IF/DE register enables
//                *_flush                bubble insert per pipeline register
//                pipe_freeze            hold all pipeline registers
//                fwd_a_sel, fwd_b_sel   EX operand source selects
//                stall_cnt, flush_cnt   performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [4:0]       de_rd,
    input  logic             de_ru_write,
    input  logic             de_is_load,
    input  logic             ex_branch_taken,
    input  logic             ext_stall,
    output logic             pc_en,
    output logic             if_de_en,
    output logic             if_de_flush,
    output logic             de_ex_flush,
    output logic             ex_me_flush,
    output logic             me_wb_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int c_BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [c_BOOT_W-1:0] c_BOOT_LAST = c_BOOT_W'(BOOT_CYCLES - 1);

    hz_state_e          r_state;
    hz_state_e          w_state_nxt;
    logic [c_BOOT_W-1:0] r_boot_cnt;
    fwd_sel_e           r_fwd_a;
    fwd_sel_e           r_fwd_b;
    fwd_sel_e           w_fwd_a;
    fwd_sel_e           w_fwd_b;
    logic               w_load_use;
    logic               w_stall_inc;
    logic               w_flush_inc;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (reset),
        .i_shift    (!pipe_freeze),
        .i_bubble   (de_ex_flush),
        .i_de_rd    (de_rd),
        .i_de_wr    (de_ru_write),
        .i_de_load  (de_is_load),
        .i_rs1      (de_rs1),
        .i_rs2      (de_rs2),
        .i_use_rs1  (de_use_rs1),
        .i_use_rs2  (de_use_rs2),
        .o_fwd_a    (w_fwd_a),
        .o_fwd_b    (w_fwd_b),
        .o_load_use (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BOOT;
            r_boot_cnt  <= c_BOOT_LAST;
            r_fwd_a     <= FWD_RF;
            r_fwd_b     <= FWD_RF;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == BOOT && r_boot_cnt != '0) begin
                r_boot_cnt <= r_boot_cnt - 1'b1;
            end
            // Selects travel with the instruction into EX; a bubble reads
            // nothing, so it gets the register-file default.
            if (!pipe_freeze) begin
                r_fwd_a <= de_ex_flush ? FWD_RF : w_fwd_a;
                r_fwd_b <= de_ex_flush ? FWD_RF : w_fwd_b;
            end
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Priority in RUN/LU_STALL: freeze > taken branch > load-use.
    always_comb begin
        w_state_nxt = r_state;
        pc_en       = 1'b1;
        if_de_en    = 1'b1;
        if_de_flush = 1'b0;
        de_ex_flush = 1'b0;
        ex_me_flush = 1'b0;
        me_wb_flush = 1'b0;
        pipe_freeze = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        case (r_state)
            BOOT: begin
                if_de_flush = 1'b1;
                de_ex_flush = 1'b1;
                ex_me_flush = 1'b1;
                me_wb_flush = 1'b1;
                if (r_boot_cnt == '0) begin
                    w_state_nxt = RUN;
                end
            end
            RUN, LU_STALL: begin
                if (ext_stall) begin
                    pipe_freeze = 1'b1;
                    pc_en       = 1'b0;
                    if_de_en    = 1'b0;
                end else if (ex_branch_taken) begin
                    if_de_flush = 1'b1;
                    de_ex_flush = 1'b1;
                    w_flush_inc = 1'b1;
                    w_state_nxt = RUN;
                end else if (r_state == RUN && w_load_use) begin
                    // Hold PC and DE, push a bubble behind the load.
                    pc_en       = 1'b0;
                    if_de_en    = 1'b0;
                    de_ex_flush = 1'b1;
                    w_stall_inc = 1'b1;
                    w_state_nxt = LU_STALL;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RV32I pipeline (IF/DE/EX/ME/WB).
- Keeps its own scoreboard of destination registers in EX/ME/WB.
- Drives stall, flush and forwarding-select controls for the pipeline registers and the EX operand muxes.
- Also sequences the post-reset pipeline drain and counts stall and flush events for performance debug.

Parameters:
- BOOT_CYCLES, 4, number of cycles all pipeline registers are flushed after reset (≥1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- de_rs1  in  5  rs1 index of the instruction in DE
- de_rs2  in  5  rs2 index of the instruction in DE
- de_use_rs1  in  1  DE instruction reads rs1
- de_use_rs2  in  1  DE instruction reads rs2
- de_rd  in  5  rd of the DE instruction
- de_ru_write  in  1  DE instruction writes rd
- de_is_load  in  1  DE instruction is a load (ru_data_src==2'b01)
- ex_branch_taken  in  1  branch unit jump output, EX stage
- ext_stall  in  1  external freeze request (future multi-cycle memory)
- pc_en  out  1  PC register enable
- if_de_en  out  1  IF/DE register enable
- if_de_flush  out  1  load bubble into IF/DE
- de_ex_flush  out  1  load bubble into DE/EX (ru_write=0, dm_write=0, br_op=0)
- ex_me_flush  out  1  load bubble into EX/ME
- me_wb_flush  out  1  load bubble into ME/WB
- pipe_freeze  out  1  hold all pipeline registers
- fwd_a_sel  out  2  EX operand-A source: 00 register file, 01 ME ALU result, 10 WB write data
- fwd_b_sel  out  2  EX operand-B/rs2 source, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles since reset
- flush_cnt  out  CNT_W  taken-branch flushes since reset

Behaviour:
- FSM states are BOOT, RUN and LU_STALL.
- Reset:
  - State goes to BOOT and the boot counter is set to BOOT_CYCLES-1.
  - Scoreboard entries are cleared (wr=0, rd=0, load=0).
  - fwd_*_sel are set to 00 and both counters to 0.
- BOOT:
  - All four flush outputs are 1, pc_en=1, if_de_en=1, pipe_freeze=0.
  - The boot counter decrements each cycle. At 0 the state goes to RUN.
  - Counters do not increment.
- Scoreboard:
  - Three entries, EX/ME/WB, each {rd, wr, load}, mirroring the pipeline registers.
  - On each non-frozen edge: WB←ME, ME←EX, EX←{de_rd, de_ru_write, de_is_load}. If de_ex_flush=1, EX←bubble (wr=0).
  - A hit requires wr=1, rd≠0, rd==rs and de_use_rsX=1.
- Forwarding:
  - Computed from DE operands against the scoreboard and registered, so it is valid while that instruction is in EX.
  - EX-entry hit (non-load) gives 01, since that result sits in ME next cycle.
  - Otherwise an ME-entry hit gives 10.
  - Otherwise 00.
  - The youngest match wins.
  - A WB-entry collision with a DE read is covered by the register file's write-through and is out of scope.
- Load-use:
  - Triggered in RUN when the EX entry has load=1 and hits rs1 or rs2.
  - That cycle: pc_en=0, if_de_en=0, de_ex_flush=1, stall_cnt+1, state goes to LU_STALL.
  - LU_STALL lasts exactly one cycle with normal controls (the load is now in ME, so a re-evaluation gives fwd=10), then returns to RUN.
- Taken branch:
  - ex_branch_taken=1 in RUN or LU_STALL gives if_de_flush=1, de_ex_flush=1 and flush_cnt+1.
  - Branch priority is above load-use: the stall is suppressed, pc_en=1 and the state goes to RUN.
- ext_stall=1:
  - Outputs pipe_freeze=1, pc_en=0, if_de_en=0 and all flushes 0.
  - Scoreboard, FSM, fwd selects and counters hold.
  - Ignored in BOOT.
- Counters wrap modulo 2^CNT_W.
- reset during any state, including mid-stall, returns to BOOT next edge.

Decomposition:
- Package pipeline_pkg holds:
  - fwd_sel_e (FWD_RF=2'b00, FWD_ME=2'b01, FWD_WB=2'b10)
  - hz_state_e (BOOT, RUN, LU_STALL)
  - struct sb_entry_t {rd, wr, load}
  - constant RU_SRC_LOAD=2'b01
- One sub-module, hazard_scoreboard: the 3-entry shift plus hit/match logic.
- The FSM, control outputs and counters stay in the top module.

Test Plan:
1. Reset held 2 cycles, then released → all flushes=1 for exactly 4 cycles, then 0; counters=0; fwd sel=00.
2. `add x5,x1,x2` then `sub x6,x5,x3` → fwd_a_sel=01 while sub is in EX; with one nop between them → 10; with rd=x0 → 00.
3. `lw x7,0(x1)` then `add x8,x7,x7` → one cycle of pc_en=0, if_de_en=0, de_ex_flush=1; then fwd_a_sel=fwd_b_sel=10; stall_cnt=1.
4. Load-use and ex_branch_taken in the same cycle → no stall, if_de_flush=de_ex_flush=1, flush_cnt=1, stall_cnt unchanged.
5. ext_stall=1 for 3 cycles during a forwarding sequence → pipe_freeze=1; fwd selects and scoreboard unchanged; after release, forwarding resumes with the same values.
6. reset asserted while in LU_STALL → next cycle state is BOOT, all flushes=1, counters=0.
